// File: rtl/clk_meter_module.sv
// Frequency/period meter: counts rising edges of an asynchronous input over a
// fixed gate window of clkin cycles and reports the last full period seen.
module clk_meter_module #(
  parameter int SYS_FREQ    = 50_000_000,
  parameter int GATE_CYCLES = SYS_FREQ,
  parameter int CNT_W       = 32
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             no_signal,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_e state_q, state_d;

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] last_per_q, last_per_d;
  logic [1:0]       win_rises_q, win_rises_d;
  logic             have_ref_q, have_ref_d;
  logic [CNT_W-1:0] edge_inc, per_inc;

  logic [CNT_W-1:0] freq_q, period_q;
  logic             valid_q, no_signal_q, busy_q;

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = GATE;
      GATE: begin
        if (!en)                           state_d = IDLE;
        else if (gate_cnt_q == GATE_LAST)  state_d = DONE;
      end
      DONE:    state_d = en ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign edge_inc = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + 1'b1;
  assign per_inc  = (per_cnt_q  == CNT_MAX) ? CNT_MAX : per_cnt_q  + 1'b1;

  // NOTE: every _d signal gets a default before any branch so no latch is inferred.
  always_comb begin
    gate_cnt_d  = '0;
    edge_cnt_d  = edge_cnt_q;
    per_cnt_d   = per_cnt_q;
    last_per_d  = last_per_q;
    win_rises_d = win_rises_q;
    have_ref_d  = have_ref_q;

    if (state_q == GATE) begin
      gate_cnt_d = gate_cnt_q + 1'b1;
      if (rise) edge_cnt_d = edge_inc;
    end

    // DONE opens the next window; a rise seen here belongs to it.
    if (state_q == DONE) begin
      edge_cnt_d  = rise ? CNT_W'(1) : '0;
      win_rises_d = '0;
    end

    if (state_q != IDLE) begin
      per_cnt_d = per_inc;
      if (rise) begin
        if (have_ref_q) begin
          last_per_d  = per_inc;
          win_rises_d = (win_rises_d == 2'd2) ? 2'd2 : win_rises_d + 2'd1;
        end
        per_cnt_d  = '0;
        have_ref_d = 1'b1;
      end
    end

    if (state_d == IDLE) begin
      edge_cnt_d  = '0;
      per_cnt_d   = '0;
      win_rises_d = '0;
      have_ref_d  = 1'b0;
    end
  end

  // NOTE: every counter sits on the async reset; none of this is a memory array.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      per_cnt_q   <= '0;
      last_per_q  <= '0;
      win_rises_q <= '0;
      have_ref_q  <= 1'b0;
    end else begin
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      per_cnt_q   <= per_cnt_d;
      last_per_q  <= last_per_d;
      win_rises_q <= win_rises_d;
      have_ref_q  <= have_ref_d;
    end
  end

  // Results latch on the edge into DONE from the _d values, so a rise on the
  // final gate cycle is included and the new values line up with valid.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      freq_q      <= '0;
      period_q    <= '0;
      no_signal_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
      if (state_d == DONE) begin
        freq_q      <= edge_cnt_d;
        period_q    <= (win_rises_d != 2'd0) ? last_per_d : '0;
        no_signal_q <= (edge_cnt_d == '0);
      end
    end
  end

  assign freq_out   = freq_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign no_signal  = no_signal_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clk_meter_module.sv
// Bench for clk_meter_module: table of steady waveforms, hand-built window
// corner sequences and a random run, all watched by a window-level reference model.
module tb_clk_meter_module;

  localparam int GATE = 100;
  localparam int CW   = 16;
  localparam int WIN  = GATE + 1;
  localparam int MAXC = 20000;
  localparam int SATV = 65535;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] freq_out, period_out;
  logic          valid, no_signal, busy;

  int checks   = 0;
  int failures = 0;

  clk_meter_module #(
    .SYS_FREQ   (GATE),
    .GATE_CYCLES(GATE),
    .CNT_W      (CW)
  ) dut (
    .clkin     (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .freq_out  (freq_out),
    .period_out(period_out),
    .valid     (valid),
    .no_signal (no_signal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model. samp[k] is the input value the synchronizer captured on
  // edge k; a rise is credited on edge k when samp[k-2]=1 and samp[k-3]=0.
  // Window j of a run that starts on edge e0 closes on edge e0+100+101j and
  // owns the rises credited on edges e0+101j .. e0+100+101j (e0+1 for j=0).
  bit samp [MAXC];
  int cyc = 3;
  bit m_running = 1'b0;
  int m_e0 = 0;
  int rises [$];
  bit m_rise;
  bit m_valid = 1'b0;
  int m_freq = 0, m_period = 0;
  bit m_nosig = 1'b0;

  task automatic close_window();
    int j, lo, n, last_i, gap;
    j  = (cyc - m_e0) / WIN;
    lo = (j == 0) ? m_e0 + 1 : m_e0 + WIN * j;
    n = 0;
    last_i = -1;
    foreach (rises[k]) begin
      if (rises[k] >= lo && rises[k] <= cyc) begin
        n++;
        last_i = k;
      end
    end
    m_freq  = (n > SATV) ? SATV : n;
    m_nosig = (n == 0);
    if (last_i > 0) begin
      gap      = rises[last_i] - rises[last_i-1];
      m_period = (gap > SATV) ? SATV : gap;
    end else begin
      m_period = 0;
    end
    m_valid = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp[cyc]   = 1'b0;
      samp[cyc-1] = 1'b0;
      samp[cyc-2] = 1'b0;
      m_running   = 1'b0;
      m_valid     = 1'b0;
      m_freq      = 0;
      m_period    = 0;
      m_nosig     = 1'b0;
    end else begin
      cyc++;
      samp[cyc] = sig_in;
      m_rise    = samp[cyc-2] && !samp[cyc-3];
      m_valid   = 1'b0;
      if (m_running && m_rise) rises.push_back(cyc);
      if (m_running && !en) begin
        m_running = 1'b0;
      end else if (m_running && ((cyc - m_e0) % WIN) == GATE) begin
        close_window();
      end else if (!m_running && en) begin
        m_running = 1'b1;
        m_e0      = cyc;
        rises.delete();
      end
    end
  end

  always @(negedge clk) begin
    check("mon_valid",      valid,      m_valid);
    check("mon_busy",       busy,       m_running);
    check("mon_freq_out",   freq_out,   m_freq);
    check("mon_period_out", period_out, m_period);
    check("mon_no_signal",  no_signal,  m_nosig);
  end

  typedef struct {
    string name;
    int    hi;
    int    lo;
    int    fmin;
    int    fmax;
    int    per;
    bit    nosig;
  } vec_t;

  vec_t vecs [5];
  int   ph;

  task automatic drive_pattern(input int hi, input int lo);
    sig_in = (ph < hi);
    ph     = (ph + 1) % (hi + lo);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int nv, first_at, n, hold, off;

    // A 101-cycle window can hold one extra rise depending on phase.
    vecs[0] = '{"sq10",    5,  5, 10, 11, 10, 1'b0};
    vecs[1] = '{"low",     0,  1,  0,  0,  0, 1'b1};
    vecs[2] = '{"p3",      1,  2, 33, 34,  3, 1'b0};
    vecs[3] = '{"p10_nar", 2,  8, 10, 11, 10, 1'b0};
    vecs[4] = '{"p50",    20, 30,  2,  3, 50, 1'b0};

    repeat (4) @(negedge clk);
    check("reset_busy",      busy,       0);
    check("reset_valid",     valid,      0);
    check("reset_freq",      freq_out,   0);
    check("reset_period",    period_out, 0);
    check("reset_no_signal", no_signal,  0);
    rst_n = 1'b1;

    foreach (vecs[t]) begin
      en = 1'b0;
      sig_in = 1'b0;
      repeat (6) @(negedge clk);
      ph = 0;
      en = 1'b1;
      drive_pattern(vecs[t].hi, vecs[t].lo);
      nv = 0;
      first_at = 0;
      for (int k = 1; k <= 3 * WIN && nv < 2; k++) begin
        @(negedge clk);
        if (valid) begin
          nv++;
          if (nv == 1) begin
            first_at = k;
          end else begin
            check_range({vecs[t].name, "_freq"}, int'(freq_out), vecs[t].fmin, vecs[t].fmax);
            check({vecs[t].name, "_period"},   period_out, vecs[t].per);
            check({vecs[t].name, "_no_signal"}, no_signal, vecs[t].nosig);
            check({vecs[t].name, "_interval"}, k - first_at, WIN);
          end
        end
        drive_pattern(vecs[t].hi, vecs[t].lo);
      end
      if (nv < 2) check({vecs[t].name, "_timeout"}, nv, 2);
    end

    // Rise credited on the last gate edge, then a rise credited on the DONE edge.
    en = 1'b0;
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 3 * WIN; i++) begin
      @(negedge clk);
      if (i == WIN) begin
        check("lastgate_valid",  valid,      1);
        check("lastgate_freq",   freq_out,   1);
        check("lastgate_period", period_out, 0);
        check("lastgate_nosig",  no_signal,  0);
      end
      if (i == 2 * WIN) begin
        check("predone_valid",  valid,      1);
        check("predone_freq",   freq_out,   0);
        check("predone_period", period_out, 0);
        check("predone_nosig",  no_signal,  1);
      end
      if (i == 3 * WIN) begin
        check("done_rise_valid",  valid,      1);
        check("done_rise_freq",   freq_out,   1);
        check("done_rise_period", period_out, 102);
        check("done_rise_nosig",  no_signal,  0);
      end
      if (i == 98 || i == 200) sig_in = 1'b1;
      if (i == 150)            sig_in = 1'b0;
    end

    // Held-low window, abort at gate count 50, then re-enable.
    en = 1'b0;
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    wait_valid(3 * WIN, n);
    check("idle_first_valid_at", n, WIN);
    check("idle_freq",   freq_out,   0);
    check("idle_period", period_out, 0);
    check("idle_nosig",  no_signal,  1);
    wait_valid(3 * WIN, n);
    check("idle_valid_spacing", n, WIN);
    ph = 0;
    for (int i = 1; i <= 51; i++) begin
      @(negedge clk);
      drive_pattern(5, 5);
      if (i == 51) en = 1'b0;
    end
    nv = 0;
    repeat (200) begin
      @(negedge clk);
      if (valid) nv++;
      drive_pattern(5, 5);
    end
    check("abort_no_valid", nv, 0);
    check("abort_busy",     busy,       0);
    check("abort_freq",     freq_out,   0);
    check("abort_period",   period_out, 0);
    check("abort_nosig",    no_signal,  1);
    sig_in = 1'b0;
    en = 1'b1;
    wait_valid(3 * WIN, n);
    check("reenable_valid_at", n, WIN);

    // Asynchronous reset in the middle of a gate window.
    ph = 0;
    nv = 0;
    for (int k = 0; k < 4 * WIN && nv < 2; k++) begin
      @(negedge clk);
      if (valid) nv++;
      drive_pattern(5, 5);
    end
    check("prereset_windows", nv, 2);
    repeat (40) begin
      @(negedge clk);
      drive_pattern(5, 5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy",   busy,       0);
    check("async_rst_valid",  valid,      0);
    check("async_rst_freq",   freq_out,   0);
    check("async_rst_period", period_out, 0);
    check("async_rst_nosig",  no_signal,  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1);

    // Random waveform with random enable dropouts.
    hold = 0;
    off  = 0;
    en   = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (hold == 0) begin
        sig_in = 1'($urandom_range(0, 1));
        hold   = int'($urandom_range(1, 12));
      end
      hold--;
      if (off > 0) begin
        off--;
        if (off == 0) en = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        en  = 1'b0;
        off = int'($urandom_range(1, 40));
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
